updown_counter: RTL and testbench
=================================

# updown_counter

Parametrised up/down counter: programmable width, runtime terminal value, and wrap or saturate mode. Adds asynchronous active-low reset, synchronous clear, parallel load, count enable, a terminal-count pulse and a sticky overflow flag. Drop-in successor to the fixed 16-bit free-running counter, used for event counting, timers and address generation across the design.

## Interface
- WIDTH, 16: counter width in bits, ≥ 2.
- RESET_VALUE, 0: value of `count` while `reset_n` = 0; must be < 2^WIDTH.
- SATURATE, 0: 0 = wrap mode, 1 = saturate mode.

- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of `count` and `ovf`.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value applied by `load`.
- en  input  1  count enable; one step per cycle.
- up  input  1  direction: 1 = increment, 0 = decrement.
- max_value  input  WIDTH  terminal value; count range is 0..max_value.
- ovf_clr  input  1  clears sticky `ovf`.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- ovf  output  1  sticky wrap/saturate flag, registered.

## Operation
- Reset (reset_n = 0, asynchronous): count = RESET_VALUE, tc = 0, ovf = 0, held until release. The first edge after release applies normal rules.
- Per-cycle priority: clear > load > en. With none active, count holds and tc = 0.
- clear: count = 0, tc = 0, ovf = 0.
- load: count = min(load_value, max_value), tc = 0, ovf unchanged.
- en & up:
  - count < max_value: count + 1.
  - count ≥ max_value (boundary event): wrap mode gives 0; saturate mode gives max_value.
- en & !up:
  - 0 < count ≤ max_value: count − 1.
  - count = 0 (boundary event): wrap mode gives max_value; saturate mode holds 0.
  - count > max_value (max_value lowered at runtime): count = max_value, no boundary event.
- Boundary event: tc = 1 for that cycle and ovf set. tc is 1 on every attempted step at the boundary, including repeated held steps in saturate mode.
- ovf: set by a boundary event; cleared by ovf_clr or clear. A set in the same cycle as ovf_clr wins (ovf = 1).
- max_value = 0: every enabled step is a boundary event and count stays 0.
- max_value may change any cycle and is sampled on the same edge as the step.
- Arithmetic is unsigned, modulo 2^WIDTH internally; the bound comparison uses the full WIDTH.

## Timing
- Latency is one cycle: inputs sampled at edge N are visible on count, tc and ovf after edge N.
- tc and ovf are registered together with count, with no combinational path from inputs to outputs.
- tc is a single-cycle pulse unless boundary events repeat on consecutive cycles.
- Reset assertion mid-operation clears outputs immediately, without waiting for clk.
- Reset deassertion is synchronised by the integrator.

## Structure
- Shared package `counter_pkg`:
  - enum `cnt_mode_e` {CNT_WRAP, CNT_SAT};
  - direction constants CNT_UP = 1'b1 and CNT_DN = 1'b0.
  - SATURATE maps to `cnt_mode_e`.
- One combinational sub-module, `counter_step`: takes count, max_value, up and mode; returns next value and boundary flag. Reused by future multi-channel counters.
- The top level holds the registers, priority mux and ovf logic.

## Test plan
- Count 0x1234 running, reset_n pulsed low between edges -> count = 0x0000 immediately, tc = 0, ovf = 0; after release with en=1, up=1 -> 0x0001.
- Wrap up: max_value = 0xFFFF, load 0xFFFE, then en=1, up=1 for 3 cycles -> 0xFFFF, 0x0000 (tc=1, ovf=1), 0x0001 (tc=0, ovf=1).
- Wrap down: max_value = 9, count 0, en=1, up=0 -> 9 with tc=1; next cycle 8 with tc=0.
- SATURATE=1, max_value = 100, load 99, en=1, up=1 for 4 cycles -> 100, 100, 100, 100, with tc = 0, 1, 1, 1; ovf set on cycle 2.
- Priority: clear=1, load=1 (200), en=1 -> count 0, ovf 0; then load 200 with max_value 100 -> count 100. At count 50, lower max_value to 20 and step en=1, up=0 -> 20, no tc.
- Same-cycle ovf_clr with a boundary event -> ovf stays 1; ovf_clr alone next cycle -> ovf 0, count unaffected.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter family: counting mode,
// direction encodings and the mapping from the integer SATURATE
// parameter onto the mode enum.
package counter_pkg;

  // Behaviour at the boundary of the 0..max_value range.
  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Direction encodings for the 'up' input.
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Any non-zero SATURATE selects saturate mode.
  function automatic cnt_mode_e mode_from_param(input int saturate);
    return (saturate != 0) ? CNT_SAT : CNT_WRAP;
  endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational single-step function of an up/down counter bounded to
// 0..max_value. It holds no state, so multi-channel counters can
// instantiate one copy per channel.
module counter_step
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] max_value,
  input  logic             up,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary
);

  // A step either moves by one, snaps back into range, or hits the
  // boundary and then wraps or holds depending on the mode.
  always_comb begin
    next_count = count;
    boundary   = 1'b0;
    if (up == CNT_UP) begin
      if (count < max_value) begin
        next_count = count + 1'b1;
      end else begin
        // At or above the terminal value: wrap to zero or pin at max.
        boundary   = 1'b1;
        next_count = (mode == CNT_WRAP) ? '0 : max_value;
      end
    end else begin
      if (count > max_value) begin
        // max_value was lowered under us; pull back into range quietly.
        next_count = max_value;
      end else if (count == '0) begin
        boundary   = 1'b1;
        next_count = (mode == CNT_WRAP) ? max_value : '0;
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with runtime terminal value, wrap or
// saturate mode, synchronous clear and load, a registered terminal-count
// pulse and a sticky overflow flag. All outputs come straight from flops.
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH       = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int                SATURATE    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] max_value,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam cnt_mode_e MODE = mode_from_param(SATURATE);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] step_count;
  logic             step_boundary;
  logic             step_event;
  logic [WIDTH-1:0] load_clamped;

  counter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .count      (count_reg),
    .max_value  (max_value),
    .up         (up),
    .mode       (MODE),
    .next_count (step_count),
    .boundary   (step_boundary)
  );

  // A loaded value never lands outside the current counting range.
  assign load_clamped = (load_value > max_value) ? max_value : load_value;

  // A boundary only counts when the step actually takes effect.
  assign step_event = en && !load && !clear && step_boundary;

  // Priority mux clear > load > en, plus the sticky overflow update where
  // a boundary in the same cycle beats ovf_clr.
  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    ovf_next   = ovf_reg;
    if (clear) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else begin
      if (load) begin
        count_next = load_clamped;
      end else if (en) begin
        count_next = step_count;
        tc_next    = step_boundary;
      end
      if (step_event) begin
        ovf_next = 1'b1;
      end else if (ovf_clr) begin
        ovf_next = 1'b0;
      end
    end
  end

  // State registers; reset acts immediately without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= RESET_VALUE;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: a wrap-mode and a saturate-mode
// instance share all inputs; each scenario task checks its own results.
module tb_updown_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic [15:0] max_value = 16'hFFFF;
  logic        ovf_clr = 1'b0;
  logic [15:0] count, count_s;
  logic        tc, tc_s, ovf, ovf_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(16), .RESET_VALUE(16'h0000), .SATURATE(0)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .en(en), .up(up), .max_value(max_value),
    .ovf_clr(ovf_clr), .count(count), .tc(tc), .ovf(ovf)
  );

  updown_counter #(.WIDTH(16), .RESET_VALUE(16'h0000), .SATURATE(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .en(en), .up(up), .max_value(max_value),
    .ovf_clr(ovf_clr), .count(count_s), .tc(tc_s), .ovf(ovf_s)
  );

  // One clock edge, then sample 1 ns later and log the transaction.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t clr=%b ld=%b lv=%h en=%b up=%b max=%h oc=%b | wrap %h tc=%b ovf=%b | sat %h tc=%b ovf=%b",
             $time, clear, load, load_value, en, up, max_value, ovf_clr,
             count, tc, ovf, count_s, tc_s, ovf_s);
  endtask

  task automatic idle();
    clear = 1'b0; load = 1'b0; en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_count got=%h exp=%h", count, 16'h0000); end
    n_checks++; if (tc !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags got tc=%b ovf=%b exp 0 0", tc, ovf); end
    @(posedge clk); #1 reset_n = 1'b1;
    // Build up ovf=1 and count 0x1235 before pulsing reset.
    max_value = 16'hFFFF; load = 1'b1; load_value = 16'hFFFF; step();
    load = 1'b0; en = 1'b1; up = 1'b1; step();
    n_checks++; if (count !== 16'h0000 || tc !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL pre_reset_wrap got=%h tc=%b ovf=%b exp 0000 1 1", count, tc, ovf); end
    en = 1'b0; load = 1'b1; load_value = 16'h1234; step();
    load = 1'b0; en = 1'b1; step();
    n_checks++; if (count !== 16'h1235 || ovf !== 1'b1) begin n_fail++; $display("FAIL pre_reset_run got=%h ovf=%b exp 1235 1", count, ovf); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (count !== 16'h0000 || tc !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL async_reset got=%h tc=%b ovf=%b exp 0000 0 0", count, tc, ovf); end
    #2 reset_n = 1'b1;
    en = 1'b1; up = 1'b1; step();
    n_checks++; if (count !== 16'h0001) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", count, 16'h0001); end
    idle();
  endtask

  task automatic test_wrap_up();
    max_value = 16'hFFFF; load = 1'b1; load_value = 16'hFFFE; step();
    load = 1'b0; en = 1'b1; up = 1'b1; step();
    n_checks++; if (count !== 16'hFFFF || tc !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_up_1 got=%h tc=%b ovf=%b exp FFFF 0 0", count, tc, ovf); end
    step();
    n_checks++; if (count !== 16'h0000 || tc !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_up_2 got=%h tc=%b ovf=%b exp 0000 1 1", count, tc, ovf); end
    step();
    n_checks++; if (count !== 16'h0001 || tc !== 1'b0 || ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_up_3 got=%h tc=%b ovf=%b exp 0001 0 1", count, tc, ovf); end
    idle();
  endtask

  task automatic test_wrap_down();
    clear = 1'b1; step();
    n_checks++; if (count !== 16'h0000 || ovf !== 1'b0) begin n_fail++; $display("FAIL clear got=%h ovf=%b exp 0000 0", count, ovf); end
    clear = 1'b0; max_value = 16'd9; en = 1'b1; up = 1'b0; step();
    n_checks++; if (count !== 16'd9 || tc !== 1'b1) begin n_fail++; $display("FAIL wrap_down_1 got=%h tc=%b exp 0009 1", count, tc); end
    n_checks++; if (count_s !== 16'd0 || tc_s !== 1'b1) begin n_fail++; $display("FAIL sat_down_hold got=%h tc=%b exp 0000 1", count_s, tc_s); end
    step();
    n_checks++; if (count !== 16'd8 || tc !== 1'b0) begin n_fail++; $display("FAIL wrap_down_2 got=%h tc=%b exp 0008 0", count, tc); end
    idle();
  endtask

  task automatic test_saturate();
    logic [15:0] exp_tc;
    exp_tc = 16'b1110;
    clear = 1'b1; step();
    clear = 1'b0; max_value = 16'd100; load = 1'b1; load_value = 16'd99; step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (count_s !== 16'd100 || tc_s !== exp_tc[i] || ovf_s !== (i >= 1)) begin
        n_fail++;
        $display("FAIL sat_up_%0d got=%h tc=%b ovf=%b exp 0064 %b %b", i, count_s, tc_s, ovf_s, exp_tc[i], (i >= 1));
      end
    end
    idle();
  endtask

  task automatic test_priority();
    max_value = 16'd100; clear = 1'b1; load = 1'b1; load_value = 16'd200; en = 1'b1; step();
    n_checks++; if (count !== 16'd0 || ovf !== 1'b0 || count_s !== 16'd0 || ovf_s !== 1'b0) begin n_fail++; $display("FAIL prio_clear got=%h/%h ovf=%b/%b exp 0000 0", count, count_s, ovf, ovf_s); end
    clear = 1'b0; en = 1'b0; step();
    n_checks++; if (count !== 16'd100 || tc !== 1'b0) begin n_fail++; $display("FAIL load_clamp got=%h tc=%b exp 0064 0", count, tc); end
    load_value = 16'd50; step();
    load = 1'b0; max_value = 16'd20; en = 1'b1; up = 1'b0; step();
    n_checks++; if (count !== 16'd20 || tc !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL max_lowered got=%h tc=%b ovf=%b exp 0014 0 0", count, tc, ovf); end
    en = 1'b0; step();
    n_checks++; if (count !== 16'd20 || tc !== 1'b0) begin n_fail++; $display("FAIL hold got=%h tc=%b exp 0014 0", count, tc); end
    idle();
  endtask

  task automatic test_max_zero();
    max_value = 16'd0; en = 1'b1; up = 1'b1; step();
    n_checks++; if (count !== 16'd0 || tc !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL max_zero_1 got=%h tc=%b ovf=%b exp 0000 1 1", count, tc, ovf); end
    step();
    n_checks++; if (count !== 16'd0 || tc !== 1'b1 || count_s !== 16'd0 || tc_s !== 1'b1) begin n_fail++; $display("FAIL max_zero_2 got=%h/%h tc=%b/%b exp 0000 1", count, count_s, tc, tc_s); end
    idle();
  endtask

  task automatic test_ovf_clr();
    clear = 1'b1; step();
    clear = 1'b0; max_value = 16'd9; en = 1'b1; up = 1'b0; ovf_clr = 1'b1; step();
    n_checks++; if (count !== 16'd9 || tc !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%h tc=%b ovf=%b exp 0009 1 1", count, tc, ovf); end
    en = 1'b0; step();
    n_checks++; if (count !== 16'd9 || tc !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%h tc=%b ovf=%b exp 0009 0 0", count, tc, ovf); end
    idle();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_max_zero();
    test_ovf_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
